// File: rtl/uart_pkg.sv
// Shared UART constants and types used by the receive path and the transmitter.
package uart_pkg;

  localparam int unsigned UART_OVERSAMPLE = 16;
  localparam int unsigned UART_DATA_BITS  = 8;

  typedef logic [$clog2(UART_OVERSAMPLE)-1:0] edge_cnt_t;
  typedef logic [$clog2(UART_DATA_BITS)-1:0]  bit_cnt_t;
  typedef logic [UART_DATA_BITS-1:0]          uart_byte_t;

  localparam edge_cnt_t UART_MID_START = 4'd7;
  localparam edge_cnt_t UART_LAST_EDGE = 4'd15;
  localparam bit_cnt_t  UART_LAST_BIT  = 3'd7;

  // True on the oversampling tick that lands on the requested edge count.
  function automatic logic tick_at(input logic tick, input edge_cnt_t cnt, input edge_cnt_t target);
    return tick && (cnt == target);
  endfunction

endpackage

// File: rtl/uart_receiver_if.sv
// Bus-side view of the UART receiver: received byte, level-valid/read handshake, sticky flags.
interface uart_receiver_if;
  import uart_pkg::*;

  logic       rx_read;
  logic       err_clear;
  uart_byte_t rx_data;
  logic       rx_data_valid;
  logic       busy;
  logic       frame_error;
  logic       overrun;

  modport master (
    output rx_read,
    output err_clear,
    input  rx_data,
    input  rx_data_valid,
    input  busy,
    input  frame_error,
    input  overrun
  );

  modport slave (
    input  rx_read,
    input  err_clear,
    output rx_data,
    output rx_data_valid,
    output busy,
    output frame_error,
    output overrun
  );

endinterface

// File: rtl/uart_sync.sv
// Two-flop synchroniser for asynchronous single-bit inputs (sin, CTS, RTS).
module uart_sync #(
  parameter logic RESET_VALUE = 1'b1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic meta_r;
  logic sync_r;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta_r <= RESET_VALUE;
      sync_r <= RESET_VALUE;
    end else begin
      meta_r <= d;
      sync_r <= meta_r;
    end
  end

  assign q = sync_r;

endmodule

// File: rtl/uart_receiver.sv
// 8N1 UART receiver with 16x oversampling, mid-bit sampling and sticky framing/overrun flags.
module uart_receiver
  import uart_pkg::*;
(
  input  logic            clk,
  input  logic            rst_n,
  input  logic            sck_rising_edge,
  input  logic            sin,
  uart_receiver_if.slave  bus
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    START = 3'd1,
    DATA  = 3'd2,
    STOP  = 3'd3,
    BREAK = 3'd4
  } rx_state_e;

  logic       sin_s;
  rx_state_e  state_r;
  rx_state_e  state_nxt_s;
  edge_cnt_t  edges_counter_r;
  edge_cnt_t  edges_nxt_s;
  bit_cnt_t   bits_counter_r;
  bit_cnt_t   bits_nxt_s;
  uart_byte_t shift_reg_r;
  uart_byte_t shift_nxt_s;
  logic       mid_start_s;
  logic       last_edge_s;
  logic       byte_done_s;
  logic       stop_bad_s;

  uart_byte_t rx_data_r;
  logic       rx_data_valid_r;
  logic       frame_error_r;
  logic       overrun_r;

  uart_sync #(.RESET_VALUE(1'b1)) u_sin_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (sin),
    .q     (sin_s)
  );

  assign mid_start_s = tick_at(sck_rising_edge, edges_counter_r, UART_MID_START);
  assign last_edge_s = tick_at(sck_rising_edge, edges_counter_r, UART_LAST_EDGE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r         <= IDLE;
      edges_counter_r <= 4'd0;
      bits_counter_r  <= 3'd0;
      shift_reg_r     <= 8'h00;
    end else begin
      state_r         <= state_nxt_s;
      edges_counter_r <= edges_nxt_s;
      bits_counter_r  <= bits_nxt_s;
      shift_reg_r     <= shift_nxt_s;
    end
  end

  always_comb begin
    state_nxt_s = state_r;
    edges_nxt_s = edges_counter_r;
    bits_nxt_s  = bits_counter_r;
    shift_nxt_s = shift_reg_r;
    byte_done_s = 1'b0;
    stop_bad_s  = 1'b0;
    case (state_r)
      IDLE: begin
        if (!sin_s) begin
          state_nxt_s = START;
          edges_nxt_s = 4'd0;
        end else begin
          state_nxt_s = IDLE;
        end
      end
      START: begin
        if (mid_start_s) begin
          edges_nxt_s = 4'd0;
          if (sin_s) begin
            state_nxt_s = IDLE;
          end else begin
            state_nxt_s = DATA;
          end
        end else if (sck_rising_edge) begin
          edges_nxt_s = edges_counter_r + 4'd1;
        end else begin
          edges_nxt_s = edges_counter_r;
        end
      end
      DATA: begin
        if (sck_rising_edge) begin
          edges_nxt_s = edges_counter_r + 4'd1;
        end else begin
          edges_nxt_s = edges_counter_r;
        end
        // Sampling at edge 15 after the mid-start realignment lands in the middle of each bit.
        if (last_edge_s) begin
          shift_nxt_s = {sin_s, shift_reg_r[UART_DATA_BITS-1:1]};
          if (bits_counter_r == UART_LAST_BIT) begin
            bits_nxt_s  = 3'd0;
            state_nxt_s = STOP;
          end else begin
            bits_nxt_s  = bits_counter_r + 3'd1;
          end
        end else begin
          shift_nxt_s = shift_reg_r;
        end
      end
      STOP: begin
        if (sck_rising_edge) begin
          edges_nxt_s = edges_counter_r + 4'd1;
        end else begin
          edges_nxt_s = edges_counter_r;
        end
        if (last_edge_s) begin
          if (sin_s) begin
            byte_done_s = 1'b1;
            state_nxt_s = IDLE;
          end else begin
            stop_bad_s  = 1'b1;
            state_nxt_s = BREAK;
          end
        end else begin
          state_nxt_s = STOP;
        end
      end
      BREAK: begin
        // Hold here while the line stays low so a break cannot look like a new start bit.
        if (sin_s) begin
          state_nxt_s = IDLE;
        end else begin
          state_nxt_s = BREAK;
        end
      end
      default: begin
        state_nxt_s = IDLE;
        edges_nxt_s = 4'd0;
        bits_nxt_s  = 3'd0;
      end
    endcase
  end

  // Completion beats a same-cycle read; error set beats a same-cycle clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_data_r       <= 8'h00;
      rx_data_valid_r <= 1'b0;
      frame_error_r   <= 1'b0;
      overrun_r       <= 1'b0;
    end else begin
      if (byte_done_s) begin
        rx_data_r       <= shift_reg_r;
        rx_data_valid_r <= 1'b1;
      end else if (bus.rx_read) begin
        rx_data_valid_r <= 1'b0;
      end
      if (byte_done_s && rx_data_valid_r && !bus.rx_read) begin
        overrun_r <= 1'b1;
      end else if (bus.err_clear) begin
        overrun_r <= 1'b0;
      end
      if (stop_bad_s) begin
        frame_error_r <= 1'b1;
      end else if (bus.err_clear) begin
        frame_error_r <= 1'b0;
      end
    end
  end

  assign bus.rx_data       = rx_data_r;
  assign bus.rx_data_valid = rx_data_valid_r;
  assign bus.frame_error   = frame_error_r;
  assign bus.overrun       = overrun_r;
  assign bus.busy          = (state_r != IDLE);

endmodule

// File: tb/tb_uart_receiver.sv
// Self-checking bench for uart_receiver: directed and random 8N1 frames against a byte-level model.
module tb_uart_receiver;

  logic       clk   = 1'b0;
  logic       rst_n = 1'b0;
  logic       sck   = 1'b0;
  logic       sin   = 1'b1;
  logic [1:0] div   = 2'd0;
  logic       valid_q = 1'b0;
  int         n_rises = 0;

  int n_checks = 0;
  int n_pass   = 0;
  int n_fail   = 0;

  // Reference model of the bus-visible state
  logic [7:0] m_data  = 8'h00;
  logic       m_valid = 1'b0;
  logic       m_fe    = 1'b0;
  logic       m_ov    = 1'b0;
  int         m_rises = 0;

  uart_receiver_if bus ();

  uart_receiver dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .sck_rising_edge (sck),
    .sin             (sin),
    .bus             (bus.slave)
  );

  always #5 clk = ~clk;

  // Oversampling tick: one clk in four, updated on the falling edge
  always @(negedge clk) begin
    div <= div + 2'd1;
    sck <= (div == 2'd3);
  end

  always @(posedge clk) begin
    valid_q <= bus.rx_data_valid;
    if (bus.rx_data_valid && !valid_q) n_rises <= n_rises + 1;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic wait_ticks(input int n);
    repeat (n) begin
      @(posedge clk);
      while (!sck) @(posedge clk);
    end
    #1;
  endtask

  task automatic check_all(input string tag, input logic exp_busy);
    chk({tag, " rx_data"},     {24'd0, bus.rx_data},       {24'd0, m_data});
    chk({tag, " valid"},       {31'd0, bus.rx_data_valid}, {31'd0, m_valid});
    chk({tag, " frame_error"}, {31'd0, bus.frame_error},   {31'd0, m_fe});
    chk({tag, " overrun"},     {31'd0, bus.overrun},       {31'd0, m_ov});
    chk({tag, " busy"},        {31'd0, bus.busy},          {31'd0, exp_busy});
  endtask

  task automatic model_frame(input logic [7:0] d, input logic stop_ok, input logic rd);
    if (stop_ok) begin
      if (m_valid && !rd) m_ov = 1'b1;
      if (!m_valid) m_rises++;
      m_data  = d;
      m_valid = 1'b1;
    end else begin
      m_fe = 1'b1;
      if (rd) m_valid = 1'b0;
    end
  endtask

  task automatic model_reset();
    m_data  = 8'h00;
    m_valid = 1'b0;
    m_fe    = 1'b0;
    m_ov    = 1'b0;
  endtask

  // Drives one frame starting just after a tick; rd pulses rx_read on the stop-sample edge.
  task automatic send_frame(input logic [7:0] d, input logic stop_bit, input logic rd);
    sin = 1'b0;
    wait_ticks(16);
    for (int i = 0; i < 8; i++) begin
      sin = d[i];
      wait_ticks(16);
    end
    sin = stop_bit;
    if (rd) begin
      wait_ticks(7);
      repeat (3) @(posedge clk);
      #1 bus.rx_read = 1'b1;
      @(posedge clk);
      #1 bus.rx_read = 1'b0;
      wait_ticks(8);
    end else begin
      wait_ticks(16);
    end
    model_frame(d, stop_bit, rd);
  endtask

  task automatic pulse_read();
    bus.rx_read = 1'b1;
    @(posedge clk);
    #1 bus.rx_read = 1'b0;
    m_valid = 1'b0;
  endtask

  task automatic pulse_clear();
    bus.err_clear = 1'b1;
    @(posedge clk);
    #1 bus.err_clear = 1'b0;
    m_fe = 1'b0;
    m_ov = 1'b0;
  endtask

  initial begin
    logic [7:0] d;
    logic       stop_ok;
    logic       rd;
    int         act;

    bus.rx_read   = 1'b0;
    bus.err_clear = 1'b0;

    // Reset values
    repeat (3) @(posedge clk);
    #1;
    check_all("reset", 1'b0);
    rst_n = 1'b1;
    wait_ticks(2);

    // Nominal byte
    send_frame(8'hA5, 1'b1, 1'b0);
    check_all("nominal", 1'b0);
    chk("nominal rises", n_rises, m_rises);
    pulse_read();
    chk("read clears valid", {31'd0, bus.rx_data_valid}, {31'd0, m_valid});
    pulse_read();
    chk("read while empty", {31'd0, bus.rx_data_valid}, 32'd0);

    // Glitch shorter than half a bit
    sin = 1'b0;
    wait_ticks(3);
    sin = 1'b1;
    wait_ticks(16);
    check_all("glitch", 1'b0);

    // Framing error followed by a held-low line
    send_frame(8'h3C, 1'b0, 1'b0);
    wait_ticks(40);
    check_all("break held", 1'b1);
    sin = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    check_all("break released", 1'b0);
    pulse_clear();
    check_all("err_clear", 1'b0);
    wait_ticks(1);

    // Overrun
    send_frame(8'h11, 1'b1, 1'b0);
    send_frame(8'h22, 1'b1, 1'b0);
    check_all("overrun", 1'b0);
    pulse_clear();
    wait_ticks(1);

    // Read in the completion cycle
    send_frame(8'h22, 1'b1, 1'b1);
    check_all("same-cycle read", 1'b0);
    chk("rises after same-cycle", n_rises, m_rises);

    // Random frames with random bus-side actions
    for (int k = 0; k < 8; k++) begin
      d       = 8'($urandom_range(0, 255));
      stop_ok = ($urandom_range(0, 4) != 0);
      rd      = ($urandom_range(0, 3) == 0);
      send_frame(d, stop_ok, rd);
      if (!stop_ok) begin
        wait_ticks($urandom_range(1, 20));
        chk("rand break busy", {31'd0, bus.busy}, 32'd1);
        sin = 1'b1;
        repeat (4) @(posedge clk);
        #1;
      end
      check_all("rand frame", 1'b0);
      act = $urandom_range(0, 3);
      if (act == 1 || act == 3) pulse_read();
      if (act == 2 || act == 3) pulse_clear();
      check_all("rand action", 1'b0);
      chk("rand rises", n_rises, m_rises);
      wait_ticks(1);
    end

    // Make sure a byte is pending so the reset has something to discard
    send_frame(8'h77, 1'b1, 1'b0);

    // Reset during bit 4 of 0xFF
    sin = 1'b0;
    wait_ticks(16);
    for (int i = 0; i < 4; i++) begin
      sin = 1'b1;
      wait_ticks(16);
    end
    wait_ticks(8);
    chk("mid-frame busy", {31'd0, bus.busy}, 32'd1);
    rst_n = 1'b0;
    #1;
    model_reset();
    check_all("mid-frame reset", 1'b0);
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    wait_ticks(2);
    check_all("after reset", 1'b0);
    send_frame(8'h5A, 1'b1, 1'b0);
    check_all("post-reset byte", 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/uart_receiver.md
# uart_receiver

UART receive path for the SoC UART peripheral: deserialises 8N1 frames (1 start, 8 data LSB-first, 1 stop) arriving on `sin`. It uses the same 16x oversampling tick (`sck_rising_edge`) as the transmitter. It presents each received byte to the bus-side register block through a level-valid / read-acknowledge handshake, with sticky framing and overrun error flags.

## Interface
- No parameters. Frame format and 16x oversampling are fixed; constants come from the shared package.
- Reset: `rst_n`, asynchronous, active-low. Clock: `clk`.
- `clk`  in  1  system clock
- `rst_n`  in  1  asynchronous active-low reset
- `sck_rising_edge`  in  1  one-`clk` pulse at 16x baud rate
- `sin`  in  1  serial input, asynchronous to `clk`, idle high
- `rx_read`  in  1  one-cycle pulse: consumer has taken `rx_data`
- `err_clear`  in  1  one-cycle pulse: clears `frame_error` and `overrun`
- `rx_data`  out  8  last correctly framed byte
- `rx_data_valid`  out  1  level; high while an unread byte is held in `rx_data`
- `busy`  out  1  high in every state except IDLE
- `frame_error`  out  1  sticky; stop bit sampled as 0
- `overrun`  out  1  sticky; new byte completed while the previous byte was unread

## Operation
- `sin` passes through a 2-flop synchroniser (reset value 1) to give `sin_s`. All decisions use `sin_s`.
- Counters:
  - 4-bit `edges_counter` increments on `sck_rising_edge` and wraps 15 -> 0 naturally.
  - 3-bit `bits_counter` counts data bits.
- **IDLE:** if `sin_s == 0`, go to START with `edges_counter = 0`.
- **START:** on the tick where `edges_counter == 7` (mid start bit):
  - if `sin_s == 1`: false start, return to IDLE, counter cleared;
  - else: clear counter, go to DATA.
- **DATA:** on the tick where `edges_counter == 15` (mid data bit):
  - shift `shift_reg = {sin_s, shift_reg[7:1]}`;
  - when `bits_counter == 7`, clear it and go to STOP; otherwise increment it.
- **STOP:** on the tick where `edges_counter == 15` (mid stop bit):
  - if `sin_s == 1`: `rx_data <= shift_reg`, `rx_data_valid <= 1`, go to IDLE;
  - else: `frame_error <= 1`, `rx_data` and `rx_data_valid` unchanged, go to BREAK.
- **BREAK:** wait until `sin_s == 1`, then go to IDLE. This prevents a line held low from retriggering a start.
- Byte completion while `rx_data_valid == 1` and no `rx_read` in the same cycle:
  - `overrun <= 1`;
  - `rx_data` is overwritten with the new byte;
  - `rx_data_valid` stays 1.
- `rx_read` with `rx_data_valid == 1` clears valid on the next edge.
- `rx_read` in the same cycle as byte completion: the completion wins. Valid stays 1, new data is loaded, no overrun.
- `err_clear` clears both sticky flags. If it coincides with a new error event, the set wins.
- `rx_read` while valid is 0 has no effect.

## Timing
- Reset values:
  - state IDLE, both counters 0, `shift_reg` 0;
  - `rx_data` 0x00, `rx_data_valid` 0, `busy` 0, `frame_error` 0, `overrun` 0.
- `busy` is combinational from state.
- All other outputs are registered.
- Synchroniser latency is 2 `clk` cycles from a `sin` edge to `sin_s`.
- Start detection, then IDLE -> START, takes 1 `clk` after `sin_s` falls.
- Frame duration from the start-detect tick to the stop sample is 8 + 16·8 + 16 = 152 ticks (counting from the start detect).
- `rx_data_valid` rises 1 `clk` after the `clk` edge carrying the stop-sample tick.
- Reset mid-frame aborts immediately: outputs take their reset values and the partial byte is discarded.
- A tick arriving while in IDLE or BREAK does not advance `edges_counter`.

## Structure
- Shared package `uart_pkg` holds:
  - `UART_OVERSAMPLE = 16`, `UART_DATA_BITS = 8`;
  - `UART_MID_START = 7`, `UART_LAST_EDGE = 15`.
- The transmitter migrates to the same package.
- The receiver state enum (IDLE, START, DATA, STOP, BREAK; 3 bits) stays local to the module.
- Sub-module `uart_sync`: 2-flop synchroniser with a reset-value parameter, reusable for CTS/RTS.

## Test plan
- **Nominal byte:** tick every 4 `clk`; send 0xA5 via the transmitter loopback -> `rx_data = 0xA5`, valid rises once, `busy` returns to 0, no flags.
- **Glitch rejection:** `sin` low for 3 ticks then high -> return to IDLE after the mid-start check, valid stays 0, no flags.
- **Framing error:** send 0x3C with stop bit 0, `sin` held low 40 more ticks -> `frame_error = 1`, valid 0, `busy` = 1 until `sin` high, then IDLE; `err_clear` -> flag 0.
- **Overrun:** send 0x11 then 0x22 with no `rx_read` -> `rx_data = 0x22`, valid 1, `overrun = 1`.
- **Same-cycle read:** pulse `rx_read` in the completion cycle of 0x22 -> valid 1, `overrun = 0`.
- **Reset mid-frame:** assert `rst_n = 0` at bit 4 of 0xFF -> all outputs at reset values; next 0x5A is received correctly.
